// File: rtl/mux_scan_reg_pkg.sv
// Shared definitions for the registered scan multiplexer.
//   mode_e : operating mode encoding (manual select / auto-scan)
//   clog2  : ceiling log2, usable in parameter/localparam expressions
package mux_scan_reg_pkg;

   typedef enum logic {
      MODE_MANUAL = 1'b0,
      MODE_AUTO   = 1'b1
   } mode_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/mux_scan_reg_if.sv
// Channel/control bundle for mux_scan_reg.
//   data_in : packed channels, channel k at [k*WIDTH +: WIDTH]
//   sel     : manual channel select
//   mode    : MODE_MANUAL / MODE_AUTO
//   hold    : freeze outputs and scan state
//   y       : registered selected data
//   ch_out  : channel index currently on y
//   valid   : one-cycle new-channel / new-dwell strobe
//   sel_err : registered manual select out-of-range flag
// master = the side driving data/controls, slave = the mux itself.
interface mux_scan_reg_if
   import mux_scan_reg_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int N_CH  = 4,
   parameter int SEL_W = 2
);
   logic [N_CH*WIDTH-1:0] data_in;
   logic [SEL_W-1:0]      sel;
   mode_e                 mode;
   logic                  hold;
   logic [WIDTH-1:0]      y;
   logic [SEL_W-1:0]      ch_out;
   logic                  valid;
   logic                  sel_err;

   modport master (
      output data_in, sel, mode, hold,
      input  y, ch_out, valid, sel_err
   );

   modport slave (
      input  data_in, sel, mode, hold,
      output y, ch_out, valid, sel_err
   );
endinterface

// File: rtl/mux_scan_reg_scan_counter.sv
// Dwell prescaler plus round-robin channel pointer for auto-scan.
//   clk, reset : clock, synchronous active-high reset
//   en         : count this cycle (auto mode, not held)
//   restart    : force prescaler and pointer back to 0 (entry into auto)
//   ptr        : current channel pointer
//   ptr_next   : pointer value after this edge
//   advance    : pointer steps on this edge
module mux_scan_reg_scan_counter
   import mux_scan_reg_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int SCAN_DIV = 16,
   parameter int SEL_W    = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             restart,
   output logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] ptr_next,
   output logic             advance
);
   localparam int               PW         = clog2(SCAN_DIV) + 1;
   localparam logic [PW-1:0]    PRESC_LAST = PW'(SCAN_DIV - 1);
   localparam logic [SEL_W-1:0] PTR_LAST   = SEL_W'(N_CH - 1);

   logic [PW-1:0] presc, presc_next;

   always_comb begin
      presc_next = presc;
      ptr_next   = ptr;
      advance    = en && !restart && (presc == PRESC_LAST);
      if (restart) begin
         presc_next = '0;
         ptr_next   = '0;
      end else if (advance) begin
         presc_next = '0;
         ptr_next   = (ptr == PTR_LAST) ? '0 : ptr + SEL_W'(1);
      end else if (en) begin
         presc_next = presc + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc <= '0;
         ptr   <= '0;
      end else begin
         presc <= presc_next;
         ptr   <= ptr_next;
      end
   end

endmodule

// File: rtl/mux_scan_reg.sv
// N-channel registered multiplexer with manual select and auto-scan.
//   clk, reset : clock, synchronous active-high reset (beats hold)
//   bus        : slave side of mux_scan_reg_if (data/controls in,
//                y/ch_out/valid/sel_err out, all registered)
//
// mode_q (last unheld mode) | meaning
// MODE_MANUAL               | y/ch_out follow sel; entering auto restarts scan
// MODE_AUTO                 | y/ch_out follow the scan pointer
module mux_scan_reg
   import mux_scan_reg_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int N_CH     = 4,
   parameter int SEL_W    = 2,
   parameter int SCAN_DIV = 16
) (
   input  logic          clk,
   input  logic          reset,
   mux_scan_reg_if.slave bus
);
   logic [WIDTH-1:0] y_q, y_d;
   logic [SEL_W-1:0] ch_q, ch_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   mode_e            mode_q, mode_d;

   logic             auto_now, auto_rise, cnt_en, advance, sel_oob;
   logic [SEL_W-1:0] ptr_next, ptr_unused, mux_idx;
   logic [WIDTH-1:0] mux_data;

   // mode_q only moves on unheld edges, so a mode change during hold is
   // seen as an edge on the first unheld cycle.
   assign auto_now  = (bus.mode == MODE_AUTO);
   assign auto_rise = !bus.hold && auto_now && (mode_q == MODE_MANUAL);
   assign cnt_en    = !bus.hold && auto_now;
   assign sel_oob   = (32'(bus.sel) >= 32'(N_CH));
   assign mux_idx   = auto_now ? ptr_next : bus.sel;

   // ch_out already mirrors the pointer in auto mode; the current value is
   // only needed inside the counter.
   mux_scan_reg_scan_counter #(
      .N_CH     (N_CH),
      .SCAN_DIV (SCAN_DIV),
      .SEL_W    (SEL_W)
   ) u_scan (
      .clk      (clk),
      .reset    (reset),
      .en       (cnt_en),
      .restart  (auto_rise),
      .ptr      (ptr_unused),
      .ptr_next (ptr_next),
      .advance  (advance)
   );

   // Out-of-range indices match no channel and yield zero.
   always_comb begin
      mux_data = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (mux_idx == SEL_W'(k)) mux_data = bus.data_in[k*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      y_d     = y_q;
      ch_d    = ch_q;
      valid_d = 1'b0;
      err_d   = err_q;
      mode_d  = mode_q;
      if (!bus.hold) begin
         mode_d = bus.mode;
         y_d    = mux_data;
         ch_d   = mux_idx;
         if (auto_now) begin
            valid_d = advance || auto_rise;
            err_d   = 1'b0;
         end else begin
            valid_d = (bus.sel != ch_q);
            err_d   = sel_oob;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         y_q     <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         mode_q  <= MODE_MANUAL;
      end else begin
         y_q     <= y_d;
         ch_q    <= ch_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         mode_q  <= mode_d;
      end
   end

   assign bus.y       = y_q;
   assign bus.ch_out  = ch_q;
   assign bus.valid   = valid_q;
   assign bus.sel_err = err_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Directed bench for mux_scan_reg: unit 0 is a 4-channel, SCAN_DIV=4 mux;
// unit 1 is a 3-channel, SCAN_DIV=1 mux (out-of-range select, non-power-of-2
// wrap, continuous valid). Expected outputs are queued before each edge and
// checked 1 ns after it.
module tb_mux_scan_reg;
   import mux_scan_reg_pkg::*;

   typedef struct packed {
      logic [3:0] y;
      logic [1:0] ch;
      logic       valid;
      logic       err;
   } obs_t;

   typedef struct {
      int    unit;
      obs_t  exp;
      string tag;
   } sb_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mux_scan_reg_if #(.WIDTH(4), .N_CH(4), .SEL_W(2)) bus_a ();
   mux_scan_reg_if #(.WIDTH(4), .N_CH(3), .SEL_W(2)) bus_b ();

   mux_scan_reg #(.WIDTH(4), .N_CH(4), .SEL_W(2), .SCAN_DIV(4)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   mux_scan_reg #(.WIDTH(4), .N_CH(3), .SEL_W(2), .SCAN_DIV(1)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   sb_t        sb_q[$];
   int         checks = 0;
   int         errors = 0;
   logic [3:0] chval[4];
   logic [3:0] man_exp[4];
   logic [3:0] bval[3];

   task automatic expect_out(input int unit, input logic [3:0] y, input logic [1:0] ch,
                             input logic v, input logic e, input string tag);
      sb_t item;
      item.unit = unit;
      item.exp  = {y, ch, v, e};
      item.tag  = tag;
      sb_q.push_back(item);
   endtask

   task automatic tick();
      sb_t  item;
      obs_t obs;
      @(posedge clk);
      #1;
      while (sb_q.size() > 0) begin
         item = sb_q.pop_front();
         if (item.unit == 0) obs = {bus_a.y, bus_a.ch_out, bus_a.valid, bus_a.sel_err};
         else                obs = {bus_b.y, bus_b.ch_out, bus_b.valid, bus_b.sel_err};
         checks++;
         assert (obs === item.exp) else begin
            errors++;
            $error("FAIL %s: observed y=%h ch=%0d valid=%b err=%b expected y=%h ch=%0d valid=%b err=%b",
                   item.tag, obs.y, obs.ch, obs.valid, obs.err,
                   item.exp.y, item.exp.ch, item.exp.valid, item.exp.err);
         end
      end
   endtask

   // Auto-scan on unit 0 with SCAN_DIV=4: step i counts edges from the
   // mode-rise edge; ch i/4 mod 4, valid on every 4th edge.
   task automatic scan_span(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         expect_out(0, chval[(i / 4) % 4], 2'((i / 4) % 4), (i % 4) == 0, 1'b0,
                    $sformatf("scan_%0d", i));
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: sequence did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      man_exp = '{4'h3, 4'hA, 4'h7, 4'hD};
      chval   = '{4'h1, 4'h2, 4'h5, 4'h8};
      bval    = '{4'h5, 4'hC, 4'h6};

      reset         = 1'b1;
      bus_a.data_in = 16'hD7A3;
      bus_a.sel     = 2'd0;
      bus_a.mode    = MODE_MANUAL;
      bus_a.hold    = 1'b0;
      bus_b.data_in = 12'h6C5;
      bus_b.sel     = 2'd0;
      bus_b.mode    = MODE_MANUAL;
      bus_b.hold    = 1'b0;

      expect_out(0, 4'h0, 2'd0, 1'b0, 1'b0, "reset_a");
      expect_out(1, 4'h0, 2'd0, 1'b0, 1'b0, "reset_b");
      tick();
      reset = 1'b0;

      // Manual select, one sel per cycle.
      for (int s = 0; s < 4; s++) begin
         bus_a.sel = 2'(s);
         expect_out(0, man_exp[s], 2'(s), s != 0, 1'b0, $sformatf("manual_sel%0d", s));
         tick();
      end
      expect_out(0, 4'hD, 2'd3, 1'b0, 1'b0, "manual_same_sel");
      tick();
      bus_a.data_in = 16'h1234;
      expect_out(0, 4'h1, 2'd3, 1'b0, 1'b0, "manual_data_change");
      tick();

      // Auto scan from mode rise.
      bus_a.data_in = 16'h8521;
      bus_a.mode    = MODE_AUTO;
      scan_span(0, 5);

      // Hold for 3 cycles at prescaler=1 on ch 1.
      bus_a.hold = 1'b1;
      for (int h = 0; h < 3; h++) begin
         expect_out(0, chval[1], 2'd1, 1'b0, 1'b0, "hold_freeze");
         tick();
      end
      bus_a.hold = 1'b0;
      scan_span(6, 9);

      // Live tracking: ch 2 data changes mid-dwell.
      bus_a.data_in[11:8] = 4'h9;
      chval[2]            = 4'h9;
      scan_span(10, 29);

      // Reset during ch 3, then a full ch 0 dwell.
      reset = 1'b1;
      expect_out(0, 4'h0, 2'd0, 1'b0, 1'b0, "reset_mid_scan");
      tick();
      reset = 1'b0;
      scan_span(0, 4);

      // Mode change while held is deferred to release.
      bus_a.hold = 1'b1;
      bus_a.mode = MODE_MANUAL;
      bus_a.sel  = 2'd3;
      for (int h = 0; h < 2; h++) begin
         expect_out(0, chval[1], 2'd1, 1'b0, 1'b0, "hold_mode_fall");
         tick();
      end
      bus_a.hold = 1'b0;
      expect_out(0, chval[3], 2'd3, 1'b1, 1'b0, "release_to_manual");
      tick();
      bus_a.hold = 1'b1;
      bus_a.mode = MODE_AUTO;
      expect_out(0, chval[3], 2'd3, 1'b0, 1'b0, "hold_mode_rise");
      tick();
      bus_a.hold = 1'b0;
      expect_out(0, chval[0], 2'd0, 1'b1, 1'b0, "release_to_auto");
      tick();
      expect_out(0, chval[0], 2'd0, 1'b0, 1'b0, "auto_dwell_after_release");
      tick();
      bus_a.mode = MODE_MANUAL;
      bus_a.sel  = 2'd2;
      expect_out(0, chval[2], 2'd2, 1'b1, 1'b0, "auto_to_manual");
      tick();

      // Unit 1: N_CH=3 out-of-range select and SCAN_DIV=1 scan.
      reset = 1'b1;
      expect_out(1, 4'h0, 2'd0, 1'b0, 1'b0, "reset_b2");
      tick();
      reset     = 1'b0;
      bus_b.sel = 2'd3;
      expect_out(1, 4'h0, 2'd3, 1'b1, 1'b1, "oob_sel3");
      tick();
      bus_b.sel = 2'd1;
      expect_out(1, bval[1], 2'd1, 1'b1, 1'b0, "oob_recover");
      tick();
      bus_b.sel  = 2'd3;
      bus_b.mode = MODE_AUTO;
      expect_out(1, bval[0], 2'd0, 1'b1, 1'b0, "div1_rise");
      tick();
      for (int k = 1; k <= 5; k++) begin
         expect_out(1, bval[k % 3], 2'(k % 3), 1'b1, 1'b0, $sformatf("div1_step%0d", k));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
